// File: rtl/key_search_controller.sv
// Sequences a brute-force RC4 key search: steps candidate keys through a range and drives
// the decrypt and verify sub-cores through their start/finish handshakes.
module key_search_controller #(
    parameter int unsigned          KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = KEY_WIDTH'(24'h3FFFFF),
    parameter logic [KEY_WIDTH-1:0] KEY_STEP  = KEY_WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    output logic                 dec_start,
    input  logic                 dec_finish,
    output logic                 ver_start,
    input  logic                 ver_finish,
    input  logic                 ver_result,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [KEY_WIDTH-1:0] attempts
);

    typedef enum logic [3:0] {
        StIdle, StLoadKey, StDecStart, StDecArm, StDecWait, StVerStart,
        StVerArm, StVerWait, StNextKey, StFound, StExhausted, StStopped
    } state_e;

    state_e             state;
    state_e             state_next;
    logic [KEY_WIDTH:0] key_sum;

    // One extra bit so the end-of-range test can never be fooled by wrap-around.
    assign key_sum = {1'b0, secret_key} + {1'b0, KEY_STEP};

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle, StFound, StExhausted, StStopped: begin
                if (start) state_next = StLoadKey;
            end
            StLoadKey:  state_next = StDecStart;
            StDecStart: state_next = StDecArm;
            // Sub-cores still show the previous finish level for one cycle after start.
            StDecArm:   state_next = StDecWait;
            StDecWait: begin
                if (dec_finish) state_next = StVerStart;
            end
            StVerStart: state_next = StVerArm;
            StVerArm:   state_next = StVerWait;
            StVerWait: begin
                if (ver_finish) state_next = ver_result ? StFound : StNextKey;
            end
            StNextKey: begin
                if (stop) begin
                    state_next = StStopped;
                end else if (key_sum > {1'b0, KEY_END}) begin
                    state_next = StExhausted;
                end else begin
                    state_next = StDecStart;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned to the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            secret_key <= '0;
            attempts   <= '0;
            dec_start  <= 1'b0;
            ver_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
        end else begin
            state     <= state_next;
            dec_start <= (state_next == StDecStart);
            ver_start <= (state_next == StVerStart);
            busy      <= !(state_next inside {StIdle, StFound, StExhausted, StStopped});
            done      <= (state_next inside {StFound, StExhausted, StStopped});
            found     <= (state_next == StFound);
            if (state == StLoadKey) begin
                secret_key <= KEY_START;
                attempts   <= '0;
            end
            if (state == StVerWait && ver_finish && attempts != '1) begin
                attempts <= attempts + KEY_WIDTH'(1);
            end
            if (state == StNextKey && state_next == StDecStart) begin
                secret_key <= key_sum[KEY_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_key_search_controller.sv
// Directed bench for key_search_controller: four instances with different key ranges, each
// paired with behavioural decrypt/verify models that hold finish high one cycle after start.
module tb_key_search_controller;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start [N];
    logic        stop [N];
    logic [23:0] match_key [N];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_core
        logic        dec_start, dec_finish, ver_start, ver_finish, ver_result;
        logic        busy, done, found;
        logic [23:0] secret_key, attempts;
        int          dcnt, vcnt;
        logic        vres;
        int          dec_pulses = 0;
        int          proto_err = 0;

        key_search_controller #(
            .KEY_WIDTH (24),
            .KEY_START ((g >= 2) ? 24'd1 : 24'd0),
            .KEY_END   ((g == 0) ? 24'd15 : (g == 1) ? 24'd3 : (g == 2) ? 24'd9 : 24'd10),
            .KEY_STEP  ((g >= 2) ? 24'd2 : 24'd1)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start[g]),
            .stop       (stop[g]),
            .dec_start  (dec_start),
            .dec_finish (dec_finish),
            .ver_start  (ver_start),
            .ver_finish (ver_finish),
            .ver_result (ver_result),
            .secret_key (secret_key),
            .busy       (busy),
            .done       (done),
            .found      (found),
            .attempts   (attempts)
        );

        // Count LAT+1 is the stale-high cycle; LAT..1 are busy cycles.
        assign dec_finish = !(dcnt != 0 && dcnt <= LAT);
        assign ver_finish = !(vcnt != 0 && vcnt <= LAT);
        assign ver_result = ver_finish && vres;

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dcnt <= 0;
                vcnt <= 0;
                vres <= 1'b0;
            end else begin
                if (dec_start) dcnt <= LAT + 1;
                else if (dcnt != 0) dcnt <= dcnt - 1;
                if (ver_start) begin
                    vcnt <= LAT + 1;
                    vres <= (secret_key == match_key[g]);
                end else if (vcnt != 0) begin
                    vcnt <= vcnt - 1;
                end
            end
        end

        always @(posedge clk) begin
            if (dec_start) dec_pulses <= dec_pulses + 1;
            if (reset_n && (dec_start || ver_start) && (dcnt != 0 || vcnt != 0))
                proto_err <= proto_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t0, p0, t1, t2, t3;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0;
            stop[i] = 1'b0;
            match_key[i] = 24'hFFFFFF;
        end
        repeat (2) tick();
        check("rst_busy", g_core[0].busy, 0);
        check("rst_done", g_core[0].done, 0);
        check("rst_found", g_core[0].found, 0);
        check("rst_key", g_core[0].secret_key, 0);
        check("rst_attempts", g_core[0].attempts, 0);
        check("rst_dec_start", g_core[0].dec_start, 0);
        check("rst_ver_start", g_core[0].ver_start, 0);
        reset_n = 1'b1;
        tick();

        // stop while idle does nothing
        stop[0] = 1'b1;
        repeat (3) tick();
        check("idle_stop_busy", g_core[0].busy, 0);
        check("idle_stop_done", g_core[0].done, 0);
        stop[0] = 1'b0;

        // Match on key 5 in range 0..15
        match_key[0] = 24'd5;
        p0 = g_core[0].dec_pulses;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        t0 = cyc;
        check("start_busy", g_core[0].busy, 1);
        tick();
        check("first_dec_start", g_core[0].dec_start, 1);
        while (!g_core[0].done && cyc - t0 < 500) tick();
        check("match_cycles", cyc - t0, 66);
        check("match_found", g_core[0].found, 1);
        check("match_key", g_core[0].secret_key, 5);
        check("match_attempts", g_core[0].attempts, 6);
        check("match_pulses", g_core[0].dec_pulses - p0, 6);
        check("match_busy", g_core[0].busy, 0);

        // Exhaustion (0..3, mid-search start ignored) and interleave (1..9, 1..10 step 2)
        start[1] = 1'b1;
        start[2] = 1'b1;
        start[3] = 1'b1;
        tick();
        start[1] = 1'b0;
        start[2] = 1'b0;
        start[3] = 1'b0;
        t1 = -1;
        t2 = -1;
        t3 = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 15) start[1] = 1'b1;
            if (c == 16) start[1] = 1'b0;
            if (t1 < 0 && g_core[1].done) t1 = c;
            if (t2 < 0 && g_core[2].done) t2 = c;
            if (t3 < 0 && g_core[3].done) t3 = c;
        end
        check("exh_cycles", t1, 45);
        check("exh_found", g_core[1].found, 0);
        check("exh_done", g_core[1].done, 1);
        check("exh_key", g_core[1].secret_key, 3);
        check("exh_attempts", g_core[1].attempts, 4);
        check("exh_pulses", g_core[1].dec_pulses, 4);
        check("il9_cycles", t2, 56);
        check("il9_key", g_core[2].secret_key, 9);
        check("il9_attempts", g_core[2].attempts, 5);
        check("il9_pulses", g_core[2].dec_pulses, 5);
        check("il10_cycles", t3, 56);
        check("il10_key", g_core[3].secret_key, 9);
        check("il10_attempts", g_core[3].attempts, 5);
        check("il10_found", g_core[3].found, 0);

        // Stop raised during 3rd key's DEC_WAIT: first with no match, then with key 2 passing
        for (int pass = 0; pass < 2; pass++) begin
            match_key[0] = (pass == 0) ? 24'hFFFFFF : 24'd2;
            p0 = g_core[0].dec_pulses;
            start[0] = 1'b1;
            tick();
            start[0] = 1'b0;
            t0 = cyc;
            while (g_core[0].dec_pulses - p0 < 3 && cyc - t0 < 200) tick();
            tick();
            check("stop_in_dec_wait", g_core[0].dec_finish, 0);
            stop[0] = 1'b1;
            while (!g_core[0].done && cyc - t0 < 200) tick();
            stop[0] = 1'b0;
            check("stop_done", g_core[0].done, 1);
            check("stop_found", g_core[0].found, pass);
            check("stop_attempts", g_core[0].attempts, 3);
            check("stop_key", g_core[0].secret_key, 2);
            check("stop_pulses", g_core[0].dec_pulses - p0, 3);
            check("stop_busy", g_core[0].busy, 0);
        end

        // Reset during VER_WAIT of key 1
        match_key[0] = 24'hFFFFFF;
        p0 = g_core[0].dec_pulses;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        t0 = cyc;
        while (!(g_core[0].ver_start && g_core[0].dec_pulses - p0 == 2) && cyc - t0 < 200) tick();
        repeat (2) tick();
        check("pre_rst_busy", g_core[0].busy, 1);
        check("pre_rst_ver_wait", g_core[0].ver_finish, 0);
        check("pre_rst_key", g_core[0].secret_key, 1);
        check("pre_rst_attempts", g_core[0].attempts, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", g_core[0].busy, 0);
        check("mid_rst_key", g_core[0].secret_key, 0);
        check("mid_rst_attempts", g_core[0].attempts, 0);
        check("mid_rst_other_done", g_core[1].done, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        match_key[0] = 24'd1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        t0 = cyc;
        while (!g_core[0].done && cyc - t0 < 200) tick();
        check("restart_cycles", cyc - t0, 22);
        check("restart_found", g_core[0].found, 1);
        check("restart_key", g_core[0].secret_key, 1);
        check("restart_attempts", g_core[0].attempts, 2);

        for (int i = 0; i < N; i++) begin
            case (i)
                0: check("proto0", g_core[0].proto_err, 0);
                1: check("proto1", g_core[1].proto_err, 0);
                2: check("proto2", g_core[2].proto_err, 0);
                default: check("proto3", g_core[3].proto_err, 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
